// File: rtl/lfsr_pkg.sv
// Shared definitions for the 16-bit Fibonacci LFSR checker and its generator model.
// Taps {15,13,12,10}; the new bit enters at bit 0 and the state shifts left.
package lfsr_pkg;

  localparam int WIDTH = 16;
  localparam int NTAPS = 4;
  localparam int TAPS [NTAPS] = '{15, 13, 12, 10};

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  function automatic logic next_bit(input logic [WIDTH-1:0] s);
    logic b;
    b = 1'b0;
    for (int i = 0; i < NTAPS; i++) begin
      b = b ^ s[TAPS[i]];
    end
    return b;
  endfunction

endpackage

// File: rtl/lfsr_window_counter.sv
// Per-window valid-bit and error counters for the locked state; flags loss of lock.
// loss is combinational on the bit that would bring the error count to LOSS_THRESH.
module lfsr_window_counter #(
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic err,
  input  logic clr,
  output logic loss
);

  localparam int BW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(LOSS_THRESH + 1);

  logic [BW-1:0] bit_cnt;
  logic [EW-1:0] err_cnt;
  logic          window_end;

  assign loss       = en && err && (err_cnt == EW'(LOSS_THRESH - 1));
  assign window_end = en && (bit_cnt == BW'(WINDOW - 1));

  // Loss and window end both restart the window, so their priority only matters to the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      err_cnt <= '0;
    end else if (clr || loss || window_end) begin
      bit_cnt <= '0;
      err_cnt <= '0;
    end else if (en) begin
      bit_cnt <= bit_cnt + BW'(1);
      err_cnt <= err_cnt + EW'(err);
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// PRBS checker: fills, searches for LOCK_COUNT good predictions, then flywheels and counts errors.
// All outputs registered, one cycle after the qualifying valid bit; bit_valid low freezes everything.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT  = 32,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear_errs,
  output logic             locked,
  output logic             err_pulse,
  output logic [15:0]      err_count,
  output logic [WIDTH-1:0] lfsr_state
);

  localparam int FW = $clog2(WIDTH);
  localparam int MW = $clog2(LOCK_COUNT + 1);

  state_t           st, st_nxt;
  logic [WIDTH-1:0] sr_nxt;
  logic [FW-1:0]    fill_cnt, fill_nxt;
  logic [MW-1:0]    match_cnt, match_nxt;
  logic             pred, mism, err_hit, loss;

  assign pred = next_bit(lfsr_state);
  assign mism = bit_in ^ pred;

  lfsr_window_counter #(
    .WINDOW      (WINDOW),
    .LOSS_THRESH (LOSS_THRESH)
  ) u_window (
    .clk   (clk),
    .reset (reset),
    .en    (bit_valid && (st == ST_LOCKED)),
    .err   (mism),
    .clr   (st != ST_LOCKED),
    .loss  (loss)
  );

  always_comb begin
    st_nxt    = st;
    sr_nxt    = lfsr_state;
    fill_nxt  = fill_cnt;
    match_nxt = match_cnt;
    err_hit   = 1'b0;
    if (bit_valid) begin
      case (st)
        ST_FILL: begin
          sr_nxt = {lfsr_state[WIDTH-2:0], bit_in};
          if (fill_cnt == FW'(WIDTH - 1)) begin
            fill_nxt = '0;
            st_nxt   = ST_SEARCH;
          end else begin
            fill_nxt = fill_cnt + FW'(1);
          end
        end
        ST_SEARCH: begin
          sr_nxt = {lfsr_state[WIDTH-2:0], bit_in};
          // An all-zero register predicts zeros forever; never let it count toward lock.
          if ((lfsr_state == '0) || mism) begin
            match_nxt = '0;
          end else if (match_cnt == MW'(LOCK_COUNT - 1)) begin
            match_nxt = '0;
            st_nxt    = ST_LOCKED;
          end else begin
            match_nxt = match_cnt + MW'(1);
          end
        end
        ST_LOCKED: begin
          // Flywheel: the prediction is shifted in so a bad bit cannot corrupt the state.
          sr_nxt  = {lfsr_state[WIDTH-2:0], pred};
          err_hit = mism;
          if (loss) begin
            st_nxt = ST_FILL;
          end
        end
        default: begin
          st_nxt    = ST_FILL;
          fill_nxt  = '0;
          match_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= ST_FILL;
      lfsr_state <= '0;
      fill_cnt   <= '0;
      match_cnt  <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
    end else begin
      st         <= st_nxt;
      lfsr_state <= sr_nxt;
      fill_cnt   <= fill_nxt;
      match_cnt  <= match_nxt;
      locked     <= (st_nxt == ST_LOCKED);
      err_pulse  <= err_hit;
      if (clear_errs) begin
        err_count <= '0;
      end else if (err_hit && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: scenario table, random gapped stream vs. model, async reset.
module tb_lfsr_checker;

  localparam int LOCK = 32;
  localparam int WIN  = 64;
  localparam int LOSS = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        clear_errs = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [15:0] lfsr_state;

  int tests = 0;
  int fails = 0;

  logic [15:0] gen;

  // Spec-level model: mode 0 fill, 1 search, 2 locked.
  int          m_mode, m_fill, m_run, m_wb, m_we, m_errs;
  logic [15:0] m_hist;
  bit          m_locked, m_pulse;

  typedef struct {
    logic [15:0] seed;
    bit          zeros;
    int          windows;
    int          flips;
    logic [15:0] exp_err;
    bit          exp_locked;
    bit          exp_loss;
  } vec_t;

  vec_t vecs [6];

  lfsr_checker dut (
    .clk        (clk),
    .reset      (reset),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .clear_errs (clear_errs),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .lfsr_state (lfsr_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic gen_step(output logic b);
    b   = gen[15] ^ gen[13] ^ gen[12] ^ gen[10];
    gen = {gen[14:0], b};
  endtask

  task automatic drive(input logic v, input logic b, input logic c);
    bit_valid  = v;
    bit_in     = b;
    clear_errs = c;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_mode = 0; m_fill = 0; m_run = 0; m_wb = 0; m_we = 0; m_errs = 0;
    m_hist = '0; m_locked = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic b, input logic c);
    logic p;
    p       = m_hist[15] ^ m_hist[13] ^ m_hist[12] ^ m_hist[10];
    m_pulse = 1'b0;
    if (v) begin
      if (m_mode == 0) begin
        m_hist = {m_hist[14:0], b};
        m_fill++;
        if (m_fill == 16) begin m_mode = 1; m_fill = 0; end
      end else if (m_mode == 1) begin
        if (m_hist == 16'h0 || b != p) m_run = 0;
        else m_run++;
        m_hist = {m_hist[14:0], b};
        if (m_run == LOCK) begin m_mode = 2; m_run = 0; end
      end else begin
        m_hist = {m_hist[14:0], p};
        m_wb++;
        if (b != p) begin
          m_pulse = 1'b1;
          m_we++;
          if (m_errs < 65535) m_errs++;
        end
        if (m_we == LOSS) begin
          m_mode = 0; m_wb = 0; m_we = 0;
        end else if (m_wb == WIN) begin
          m_wb = 0; m_we = 0;
        end
      end
    end
    if (c) m_errs = 0;
    m_locked = (m_mode == 2);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    bit_valid  = 1'b0;
    bit_in     = 1'b0;
    clear_errs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_pulse", err_pulse, 0);
    chk("rst_errs", err_count, 0);
    chk("rst_state", lfsr_state, 0);
    reset = 1'b0;
  endtask

  // 16 fill bits plus LOCK matches: locked must be low after bit 47 and high after bit 48.
  task automatic acquire(input string tag);
    logic nb;
    for (int i = 1; i <= 16 + LOCK; i++) begin
      gen_step(nb);
      drive(1'b1, nb, 1'b0);
      if (i == 16 + LOCK - 1) chk({tag, "_locked_early"}, locked, 0);
      if (i == 16 + LOCK) begin
        chk({tag, "_locked"}, locked, 1);
        chk({tag, "_state"}, lfsr_state, gen);
      end
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic nb, fb;
    bit   seen, lost;
    int   nwin;
    seen = 0;
    lost = 0;
    do_reset();
    gen = v.seed;
    if (v.zeros) begin
      for (int i = 0; i < 200; i++) begin
        drive(1'b1, 1'b0, 1'b0);
        if (locked) seen = 1;
      end
      chk($sformatf("v%0d_zero_lock", idx), seen, 0);
      chk($sformatf("v%0d_zero_errs", idx), err_count, v.exp_err);
      return;
    end
    acquire($sformatf("v%0d_acq", idx));
    for (int w = 0; w < v.windows && !lost; w++) begin
      nwin = 0;
      for (int k = 0; k < WIN && !lost; k++) begin
        gen_step(nb);
        fb = ((k % 8) == 3) && ((k / 8) < v.flips);
        drive(1'b1, nb ^ fb, 1'b0);
        chk($sformatf("v%0d_pulse_w%0d_k%0d", idx, w, k), err_pulse, fb);
        if (fb) nwin++;
        if (nwin == LOSS) begin
          chk($sformatf("v%0d_loss", idx), locked, 0);
          lost = 1;
        end else begin
          chk($sformatf("v%0d_hold_w%0d_k%0d", idx, w, k), locked, 1);
        end
      end
    end
    if (lost) acquire($sformatf("v%0d_relock", idx));
    chk($sformatf("v%0d_errs", idx), err_count, v.exp_err);
    chk($sformatf("v%0d_end_locked", idx), locked, v.exp_locked);
    chk($sformatf("v%0d_end_state", idx), lfsr_state, gen);
  endtask

  initial begin
    logic v, nb, fb, c;
    int   vcount, dut_first;

    vecs[0] = '{16'h5555, 1'b0, 0, 0, 16'd0,  1'b1, 1'b0};
    vecs[1] = '{16'h5555, 1'b0, 1, 1, 16'd1,  1'b1, 1'b0};
    vecs[2] = '{16'h5555, 1'b0, 1, 8, 16'd8,  1'b1, 1'b1};
    vecs[3] = '{16'h5555, 1'b0, 4, 7, 16'd28, 1'b1, 1'b0};
    vecs[4] = '{16'hACE1, 1'b0, 2, 3, 16'd6,  1'b1, 1'b0};
    vecs[5] = '{16'h0000, 1'b1, 0, 0, 16'd0,  1'b0, 1'b0};

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Random gapped stream with errors only while locked, checked cycle by cycle.
    do_reset();
    model_reset();
    gen       = 16'($urandom) | 16'h1;
    vcount    = 0;
    dut_first = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      v  = ($urandom_range(0, 3) != 0);
      fb = m_locked && ($urandom_range(0, 99) == 0);
      c  = ($urandom_range(0, 299) == 0);
      nb = 1'b0;
      if (v) gen_step(nb);
      drive(v, nb ^ fb, c);
      model_step(v, nb ^ fb, c);
      if (v) vcount++;
      if (locked && dut_first < 0) dut_first = vcount;
      chk("rnd_locked", locked, m_locked);
      chk("rnd_pulse", err_pulse, m_pulse);
      chk("rnd_errs", err_count, m_errs);
      chk("rnd_state", lfsr_state, m_hist);
    end
    chk("gap_lock_valid_bits", dut_first, 16 + LOCK);

    // Force a known error, then assert reset mid-cycle while locked.
    gen_step(nb);
    drive(1'b1, ~nb, 1'b0);
    model_step(1'b1, ~nb, 1'b0);
    chk("pre_rst_locked", locked, m_locked);
    chk("pre_rst_errs", err_count, m_errs);
    bit_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_locked", locked, 0);
    chk("async_rst_errs", err_count, 0);
    chk("async_rst_state", lfsr_state, 0);
    @(negedge clk);
    reset = 1'b0;
    acquire("post_rst");
    chk("post_rst_errs", err_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 32: consecutive correct predictions needed to declare lock.
REQ-002 Parameter WINDOW, default 64: valid bits per loss-evaluation window while locked.
REQ-003 Parameter LOSS_THRESH, default 8: errors within one window that force loss of lock.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 bit_in  input  1  received serial bit; equals the generator's newly inserted LSB each step.
REQ-008 bit_valid  input  1  qualifies bit_in for one clk cycle.
REQ-009 clear_errs  input  1  synchronous clear of err_count.
REQ-010 locked  output  1  checker synchronised to the stream.
REQ-011 err_pulse  output  1  one-cycle flag for a mismatched bit while locked.
REQ-012 err_count  output  16  saturating total of errors seen while locked.
REQ-013 lfsr_state  output  16  current reconstructed generator state, bit 0 = newest bit.

Function
REQ-014 Generator model SHALL be fixed: new bit = s[15]^s[13]^s[12]^s[10], state shifts left, new bit enters s[0].
REQ-015 States SHALL be FILL, SEARCH and LOCKED.
REQ-016 FILL: each valid bit shifts into the state; after 16 valid bits go to SEARCH; no comparison is made.
REQ-017 SEARCH: each valid bit is compared with the prediction from the current state, then bit_in (not the prediction) is shifted in.
REQ-018 SEARCH: a match increments the match counter; a mismatch clears it to 0.
REQ-019 SEARCH: the valid bit that brings the match counter to LOCK_COUNT moves the block to LOCKED; locked rises on the following cycle.
REQ-020 A state register of all zeros SHALL block lock: clear the match counter and stay in SEARCH.
REQ-021 LOCKED: the predicted bit (flywheel) is shifted in, never bit_in, so single errors do not corrupt the state.
REQ-022 LOCKED mismatch: err_pulse high for exactly the next cycle; err_count increments, saturating at 16'hFFFF; window error count increments.
REQ-023 The window bit counter SHALL count valid bits while LOCKED.
REQ-024 At WINDOW valid bits, both window counters clear and the window restarts.
REQ-025 When the window error count reaches LOSS_THRESH, go to FILL: clear all counters except err_count; locked falls on the next cycle.
REQ-026 If loss and window end happen on the same bit, loss SHALL win.
REQ-027 bit_valid low: no state, counter or output change; err_pulse low.
REQ-028 clear_errs high sets err_count to 0 on the next edge and wins over a simultaneous error increment; err_pulse still fires.
REQ-029 err_pulse SHALL never assert outside LOCKED.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 Reset SHALL give: state FILL, lfsr_state 16'h0000, all counters 0, locked 0, err_pulse 0, err_count 0.
REQ-032 Reset asserted mid-operation (including while LOCKED) SHALL apply these values immediately and asynchronously.
REQ-033 After reset releases, the block SHALL resume at FILL on the next valid bit.

Structure
REQ-034 Shared package lfsr_pkg SHALL hold WIDTH=16, the tap positions {15,13,12,10}, the state enumeration and a next-bit function shared with the generator.
REQ-035 One sub-module, lfsr_window_counter, SHALL hold the window bit and error counters and generate the loss condition.
REQ-036 The FSM, shift register and err_count SHALL stay in lfsr_checker.

Verification
REQ-037 Stream from a generator seeded 16'h5555 with bit_valid held high -> locked rises the cycle after valid bit 48 (16 FILL + 32 matches); lfsr_state equals the generator state.
REQ-038 While locked, flip one bit -> err_pulse exactly one cycle, err_count=1, locked stays 1, and the next predictions match.
REQ-039 While locked, flip 8 bits within one 64-bit window -> locked falls one cycle after the 8th error; after re-lock err_count=8.
REQ-040 While locked, flip 7 bits per window over 4 windows -> locked stays 1, err_count=28.
REQ-041 All-zero input stream for 200 bits -> locked never rises.
REQ-042 Random gaps in bit_valid -> lock timing counts valid bits only; assert reset while LOCKED -> locked=0 and err_count=0 with no clock edge.
